// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
package spi_sched_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned TMO_DEF = 1023;

    // Width helper that never returns 0, so single-entry fields still get one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned TMR_W_DEF = clog2(TMO_DEF + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StXfer,
        StResp,
        StHold
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search starting at ptr.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] id
);

    int idx;

    // Scan from the far end back to ptr so the closest requester is written last and wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (req[idx]) begin
                valid = 1'b1;
                id    = W'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_sched.sv
// Shares one SPI byte engine between N_REQ requesters; round-robin grant, byte
// sequencing, and slave-select hold across bursts. All outputs are registered.
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TMO   = TMO_DEF
) (
    input  logic                      GCLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*DW-1:0]       req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DW-1:0]             rsp_data,
    output logic [clog2(N_REQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      spi_start,
    output logic [DW-1:0]             spi_tx,
    output logic                      spi_ss_hold,
    input  logic                      spi_done,
    input  logic [DW-1:0]             spi_rx,
    output logic                      err_tmo
);

    localparam int unsigned GW = clog2(N_REQ);
    localparam int unsigned TW = clog2(TMO + 1);

    state_e            state_q, state_d;
    logic [GW-1:0]     gid_q, gid_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic              last_q, last_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              busy_q, busy_d;
    logic              hold_q, hold_d;
    logic              start_q, start_d;
    logic [DW-1:0]     tx_q, tx_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  rv_q, rv_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              release_bus;
    logic              arb_valid;
    logic [GW-1:0]     arb_id;

    rr_arbiter #(
        .N (N_REQ),
        .W (GW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .id    (arb_id)
    );

    always_comb begin
        state_d     = state_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        tmr_d       = tmr_q;
        busy_d      = busy_q;
        hold_d      = hold_q;
        start_d     = 1'b0;
        tx_d        = tx_q;
        ack_d       = '0;
        rv_d        = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        release_bus = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gid_d   = arb_id;
                    busy_d  = 1'b1;
                    hold_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                start_d       = 1'b1;
                tx_d          = req_data[int'(gid_q) * int'(DW) +: DW];
                ack_d[gid_q]  = 1'b1;
                last_d        = req_last[gid_q];
                tmr_d         = '0;
                state_d       = StXfer;
            end
            StXfer: begin
                // A done on the timeout cycle still counts as a completed byte.
                if (spi_done) begin
                    rdata_d      = spi_rx;
                    rv_d[gid_q]  = 1'b1;
                    state_d      = StResp;
                end else if (tmr_q == TW'(TMO)) begin
                    err_d       = 1'b1;
                    release_bus = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StResp: begin
                if (last_q) begin
                    release_bus = 1'b1;
                end else begin
                    tmr_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (req[gid_q]) begin
                    state_d = StLoad;
                end else if (tmr_q == TW'(TMO)) begin
                    release_bus = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (release_bus) begin
            hold_d  = 1'b0;
            busy_d  = 1'b0;
            ptr_d   = (gid_q == GW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            gid_q   <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            tmr_q   <= tmr_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ack         = ack_q;
    assign rsp_valid   = rv_q;
    assign rsp_data    = rdata_q;
    assign grant_id    = gid_q;
    assign busy        = busy_q;
    assign spi_start   = start_q;
    assign spi_tx      = tx_q;
    assign spi_ss_hold = hold_q;
    assign err_tmo     = err_q;

endmodule
